// File: rtl/sync_event_counter.sv
// Synchronized, glitch-filtered event counter with saturating count and a
// snapshot register handed off to a consumer through a valid/ready pair.
//
// Filter states:
//   state  | meaning
//   LO     | filtered level low, waiting for S=1
//   CHK_HI | S has been high for 'run' consecutive samples, not yet accepted
//   HI     | filtered level high, waiting for S=0
//   CHK_LO | S has been low for 'run' consecutive samples, not yet accepted
module sync_event_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             ASYNC_IN,
    input  logic             CLR,
    output logic             EVT,
    output logic             LVL,
    output logic [CNT_W-1:0] CNT_Q,
    output logic             OVF,
    input  logic             SNAP_REQ,
    output logic [CNT_W-1:0] SNAP_Q,
    output logic             SNAP_VALID,
    input  logic             SNAP_READY
);

    localparam int RUN_W = $clog2(FILT_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        LO     = 2'd0,
        CHK_HI = 2'd1,
        HI     = 2'd2,
        CHK_LO = 2'd3
    } filt_state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    filt_state_t      state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] run_inc;

    logic             evt_q;
    logic             lvl_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic [CNT_W-1:0] snap_q;
    logic             snap_valid_q;

    // Plain flop chain; nothing may sit between stages.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ASYNC_IN};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q <= LO;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    assign run_inc = run_q + RUN_ONE;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            LO: begin
                if (s) begin
                    if (FILT_LEN == 1) begin
                        state_d = HI;
                        run_d   = '0;
                    end else begin
                        state_d = CHK_HI;
                        run_d   = RUN_ONE;
                    end
                end
            end
            CHK_HI: begin
                if (s) begin
                    if (run_inc == RUN_FULL) begin
                        state_d = HI;
                        run_d   = '0;
                    end else begin
                        run_d   = run_inc;
                    end
                end else begin
                    state_d = LO;
                    run_d   = '0;
                end
            end
            HI: begin
                if (!s) begin
                    if (FILT_LEN == 1) begin
                        state_d = LO;
                        run_d   = '0;
                    end else begin
                        state_d = CHK_LO;
                        run_d   = RUN_ONE;
                    end
                end
            end
            CHK_LO: begin
                if (!s) begin
                    if (run_inc == RUN_FULL) begin
                        state_d = LO;
                        run_d   = '0;
                    end else begin
                        run_d   = run_inc;
                    end
                end else begin
                    state_d = HI;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = LO;
                run_d   = '0;
            end
        endcase
    end

    // Outputs lag the state by one edge; a HI state seen while the
    // registered level is still low marks the first cycle of a new entry.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            lvl_q <= 1'b0;
            evt_q <= 1'b0;
        end else begin
            lvl_q <= (state_q == HI) || (state_q == CHK_LO);
            evt_q <= (state_q == HI) && !lvl_q;
        end
    end

    // Saturating counter; CLR wins over a coincident event.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (CLR) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (evt_q) begin
            if (cnt_q == CNT_MAX) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // A held snapshot blocks new requests, even on the edge it is consumed.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
        end else if (snap_valid_q) begin
            if (SNAP_READY) begin
                snap_valid_q <= 1'b0;
            end
        end else if (SNAP_REQ) begin
            snap_q       <= cnt_q;
            snap_valid_q <= 1'b1;
        end
    end

    assign EVT        = evt_q;
    assign LVL        = lvl_q;
    assign CNT_Q      = cnt_q;
    assign OVF        = ovf_q;
    assign SNAP_Q     = snap_q;
    assign SNAP_VALID = snap_valid_q;

endmodule

// File: tb/tb_sync_event_counter.sv
// Directed bench for sync_event_counter: a default instance plus a 4-bit
// counter instance sharing the same stimulus.
module tb_sync_event_counter;

    logic       CLK;
    logic       R;
    logic       ASYNC_IN;
    logic       CLR;
    logic       SNAP_REQ;
    logic       SNAP_READY;

    logic       evt, lvl, ovf, snap_valid;
    logic [7:0] cnt_q, snap_q;
    logic       evt4, lvl4, ovf4, snap_valid4;
    logic [3:0] cnt_q4, snap_q4;

    int n_tests = 0;
    int n_fail  = 0;

    sync_event_counter u_dut (
        .CLK(CLK), .R(R), .ASYNC_IN(ASYNC_IN), .CLR(CLR),
        .EVT(evt), .LVL(lvl), .CNT_Q(cnt_q), .OVF(ovf),
        .SNAP_REQ(SNAP_REQ), .SNAP_Q(snap_q), .SNAP_VALID(snap_valid),
        .SNAP_READY(SNAP_READY)
    );

    sync_event_counter #(.CNT_W(4)) u_dut4 (
        .CLK(CLK), .R(R), .ASYNC_IN(ASYNC_IN), .CLR(CLR),
        .EVT(evt4), .LVL(lvl4), .CNT_Q(cnt_q4), .OVF(ovf4),
        .SNAP_REQ(SNAP_REQ), .SNAP_Q(snap_q4), .SNAP_VALID(snap_valid4),
        .SNAP_READY(SNAP_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One qualified pulse: long enough high and low to pass the filter.
    task automatic pulse();
        ASYNC_IN = 1'b1;
        repeat (6) tick();
        ASYNC_IN = 1'b0;
        repeat (6) tick();
    endtask

    task automatic clear();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bit found;

        R = 1'b0; ASYNC_IN = 1'b0; CLR = 1'b0;
        SNAP_REQ = 1'b0; SNAP_READY = 1'b0;
        repeat (2) tick();
        chk("rst_evt", evt, 0);
        chk("rst_lvl", lvl, 0);
        chk("rst_cnt", cnt_q, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_snap_q", snap_q, 0);
        chk("rst_snap_valid", snap_valid, 0);
        R = 1'b1;

        // Held high from edge 0: EVT only at edge 5, count 1 after edge 6.
        ASYNC_IN = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            chk($sformatf("lat_evt_e%0d", e), evt, (e == 5) ? 1 : 0);
            if (e == 4) chk("lat_lvl_e4", lvl, 0);
            if (e == 5) chk("lat_lvl_e5", lvl, 1);
            if (e == 5) chk("lat_cnt_e5", cnt_q, 0);
            if (e == 6) chk("lat_cnt_e6", cnt_q, 1);
        end
        ASYNC_IN = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (evt) seen = 1'b1;
        end
        chk("fall_no_evt", seen, 0);
        chk("fall_lvl", lvl, 0);
        chk("fall_cnt", cnt_q, 1);

        // Two-cycle glitch is rejected.
        clear();
        chk("clr_cnt", cnt_q, 0);
        ASYNC_IN = 1'b1;
        repeat (2) tick();
        ASYNC_IN = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (evt || lvl) seen = 1'b1;
        end
        chk("glitch_seen", seen, 0);
        chk("glitch_cnt", cnt_q, 0);

        // Saturation on the 4-bit instance.
        clear();
        for (int i = 0; i < 17; i++) begin
            pulse();
            if (i == 14) begin
                chk("sat15_cnt4", cnt_q4, 15);
                chk("sat15_ovf4", ovf4, 0);
            end
        end
        chk("sat_cnt4", cnt_q4, 15);
        chk("sat_ovf4", ovf4, 1);
        chk("sat_cnt8", cnt_q, 17);
        chk("sat_ovf8", ovf, 0);
        clear();
        chk("satclr_cnt4", cnt_q4, 0);
        chk("satclr_ovf4", ovf4, 0);
        chk("satclr_cnt8", cnt_q, 0);

        // CLR coincident with EVT at count 7: event lost.
        for (int i = 0; i < 7; i++) pulse();
        chk("pre_coinc_cnt", cnt_q, 7);
        ASYNC_IN = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (evt) found = 1'b1;
        end
        chk("coinc_evt_seen", found, 1);
        clear();
        chk("coinc_cnt", cnt_q, 0);
        ASYNC_IN = 1'b0;
        repeat (8) tick();
        chk("coinc_cnt_later", cnt_q, 0);

        // Snapshot handshake.
        for (int i = 0; i < 3; i++) pulse();
        SNAP_REQ = 1'b1;
        tick();
        chk("snap_valid_set", snap_valid, 1);
        chk("snap_q_3", snap_q, 3);
        for (int i = 0; i < 2; i++) pulse();
        chk("snap_hold_valid", snap_valid, 1);
        chk("snap_hold_q", snap_q, 3);
        chk("snap_live_cnt", cnt_q, 5);
        SNAP_READY = 1'b1;
        tick();
        chk("snap_accept_valid", snap_valid, 0);
        chk("snap_accept_q", snap_q, 3);
        SNAP_REQ = 1'b0;
        tick();
        chk("snap_idle_ready", snap_valid, 0);
        SNAP_READY = 1'b0;
        SNAP_REQ = 1'b1;
        tick();
        SNAP_REQ = 1'b0;
        chk("snap2_valid", snap_valid, 1);
        chk("snap2_q", snap_q, 5);

        // Reset while in CHK_HI, then fresh latency after release.
        ASYNC_IN = 1'b1;
        repeat (3) tick();
        #2;
        R = 1'b0;
        #1;
        chk("arst_evt", evt, 0);
        chk("arst_lvl", lvl, 0);
        chk("arst_cnt", cnt_q, 0);
        chk("arst_ovf4", ovf4, 0);
        chk("arst_snap_q", snap_q, 0);
        chk("arst_snap_valid", snap_valid, 0);
        repeat (2) tick();
        R = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            chk($sformatf("rel_evt_e%0d", e), evt, (e == 5) ? 1 : 0);
            if (e == 6) chk("rel_cnt_e6", cnt_q, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_event_counter.md
SYNC_EVENT_COUNTER -- requirements
Module: sync_event_counter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops (legal 2..4).
REQ-002 The block SHALL have parameter FILT_LEN, default 3, giving the cycles of stable level required to accept a change (legal 1..15).
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the event counter width (legal 4..16).
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock, all flops rising-edge.
REQ-005 The block SHALL have port R, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port ASYNC_IN, input, 1 bit: asynchronous event line, no timing relation to CLK.
REQ-007 The block SHALL have port CLR, input, 1 bit: synchronous clear of the counter and OVF.
REQ-008 The block SHALL have port EVT, output, 1 bit: one-cycle pulse per accepted rising edge.
REQ-009 The block SHALL have port LVL, output, 1 bit: filtered level.
REQ-010 The block SHALL have port CNT_Q, output, CNT_W bits: live event count.
REQ-011 The block SHALL have port OVF, output, 1 bit: sticky saturation flag.
REQ-012 The block SHALL have port SNAP_REQ, input, 1 bit: snapshot request, sampled each cycle.
REQ-013 The block SHALL have port SNAP_Q, output, CNT_W bits: captured count.
REQ-014 The block SHALL have port SNAP_VALID, output, 1 bit: SNAP_Q holds an unconsumed snapshot.
REQ-015 The block SHALL have port SNAP_READY, input, 1 bit: consumer accepts the snapshot.

Function
REQ-016 ASYNC_IN SHALL pass through a chain of SYNC_STAGES flops, producing S, with no logic between chain flops.
REQ-017 The filter SHALL be an FSM with states LO, CHK_HI, HI and CHK_LO, plus a run counter of ceil(log2(FILT_LEN+1)) bits.
REQ-018 In LO, S=1 SHALL go to CHK_HI with run=1; if FILT_LEN=1 it SHALL go directly to HI.
REQ-019 In CHK_HI, S=1 SHALL increment run and enter HI when run reaches FILT_LEN; S=0 SHALL return to LO with run=0.
REQ-020 HI and CHK_LO SHALL behave symmetrically to LO and CHK_HI, with S=0 as the qualifying level.
REQ-021 LVL SHALL be 1 exactly in HI and CHK_LO.
REQ-022 EVT SHALL be registered and high for exactly the first cycle of each HI entry from CHK_HI or LO; no pulse SHALL occur on HI to LO.
REQ-023 The latency from an ASYNC_IN rise captured at edge 0 SHALL be LVL=1 and EVT=1 after edge SYNC_STAGES+FILT_LEN (defaults: edge 5), with CNT_Q incremented after the following edge.
REQ-024 A pulse on S shorter than FILT_LEN cycles SHALL produce no LVL change and no EVT.
REQ-025 On an EVT cycle, CNT_Q SHALL increment by 1 modulo-free: at all-ones it SHALL hold, and OVF SHALL set the same edge and stay set.
REQ-026 CLR=1 SHALL force CNT_Q=0 and OVF=0 at the next edge; CLR and EVT in the same cycle SHALL give CNT_Q=0, and that event is lost.
REQ-027 CLR SHALL NOT affect the synchronizer, filter, or snapshot path.
REQ-028 SNAP_REQ=1 with SNAP_VALID=0 SHALL load SNAP_Q with the pre-edge CNT_Q and set SNAP_VALID at the next edge.
REQ-029 SNAP_VALID SHALL stay high and SNAP_Q stable until an edge with SNAP_READY=1; that edge SHALL clear SNAP_VALID.
REQ-030 SNAP_REQ while SNAP_VALID=1 SHALL be ignored, including in the READY-accept cycle; a new capture SHALL require SNAP_REQ in a later cycle.
REQ-031 SNAP_READY while SNAP_VALID=0 SHALL have no effect.

Reset
REQ-032 R=0 SHALL asynchronously clear all synchronizer flops, select FSM state LO, and set run=0, EVT=0, LVL=0, CNT_Q=0, OVF=0, SNAP_Q=0, SNAP_VALID=0.
REQ-033 Reset assertion mid-filter or mid-handshake SHALL abandon the operation with no EVT or count.
REQ-034 Reset deassertion SHALL be synchronous to CLK, and the first functional edge SHALL be the one following deassertion.

Verification
REQ-035 A bench SHALL cover: defaults, ASYNC_IN held high from edge 0 -> EVT only at edge 5, LVL=1, CNT_Q=1 after edge 6.
REQ-036 A bench SHALL cover: a 2-cycle high glitch on ASYNC_IN -> EVT never asserts, CNT_Q stays 0.
REQ-037 A bench SHALL cover: CNT_W=4 with 17 qualified pulses -> CNT_Q=15 and OVF=1; then CLR -> CNT_Q=0, OVF=0.
REQ-038 A bench SHALL cover: CLR coincident with EVT while CNT_Q=7 -> CNT_Q=0 next cycle.
REQ-039 A bench SHALL cover: SNAP_REQ at CNT_Q=3 with SNAP_READY held 0 for 5 cycles and 2 more events -> SNAP_Q=3 held with VALID=1; READY=1 -> VALID=0 next edge.
REQ-040 A bench SHALL cover: R asserted in CHK_HI -> all outputs 0 immediately; after release, ASYNC_IN stable high gives a first EVT exactly SYNC_STAGES+FILT_LEN edges later.
